// File: rtl/mem_pkg.sv
// Shared types and parameter-legality helpers for the multi-read, single-write memory.
package mem_pkg;

  localparam int WORD_W = 32;
  localparam int BE_W   = WORD_W / 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [BE_W-1:0]   be_t;

  // Legal ranges for read latency and read-port count.
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;
  localparam int NRD_MIN = 1;
  localparam int NRD_MAX = 4;

  // Same-address read/write ordering selector values.
  localparam bit WR_FIRST_NEW = 1'b1;
  localparam bit WR_FIRST_OLD = 1'b0;

  function automatic bit params_ok(input int width, input int lat, input int nrd);
    return (width > 0) && (width % 8 == 0) &&
           (lat >= LAT_MIN) && (lat <= LAT_MAX) &&
           (nrd >= NRD_MIN) && (nrd <= NRD_MAX);
  endfunction

endpackage

// File: rtl/mem_rd_port.sv
// One read port: range check, write bypass, per-byte written mask and latency pipeline.
// The raw array word arrives already registered from the parent; this block registers
// everything else needed to turn that word into the returned data.
module mem_rd_port
  import mem_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 256,
  parameter  int LAT      = 1,
  parameter  bit WR_FIRST = 1'b1,
  localparam int AW       = $clog2(DEPTH),
  localparam int NBE      = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             re,
  input  logic [AW-1:0]    addr,
  input  logic             wr_ok,
  input  logic [AW-1:0]    write_addr,
  input  logic [WIDTH-1:0] write_data,
  input  logic [NBE-1:0]   write_be,
  input  logic [NBE-1:0]   flags,
  input  logic [WIDTH-1:0] ram_word,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  logic             in_range;
  logic             hit;
  logic             valid1_q, valid1_d;
  logic [NBE-1:0]   mask_q, mask_d;
  logic [NBE-1:0]   byp_q, byp_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] word1;

  // Capture bypass/mask decisions at the edge that samples the array; hold otherwise.
  always_comb begin
    in_range = 32'(addr) < 32'(DEPTH);
    hit      = wr_ok && (write_addr == addr) && in_range;
    valid1_d = re;
    mask_d   = mask_q;
    byp_d    = byp_q;
    wdata_d  = wdata_q;
    if (re) begin
      byp_d   = (hit && (WR_FIRST == WR_FIRST_NEW)) ? write_be : '0;
      mask_d  = in_range ? (flags | byp_d) : '0;
      wdata_d = write_data;
    end
  end

  // First stage registers; clearing the mask forces the output word to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1_q <= 1'b0;
      mask_q   <= '0;
      byp_q    <= '0;
      wdata_q  <= '0;
    end else begin
      valid1_q <= valid1_d;
      mask_q   <= mask_d;
      byp_q    <= byp_d;
      wdata_q  <= wdata_d;
    end
  end

  // Per-byte merge: unwritten bytes read as zero, bypassed bytes come from the write.
  always_comb begin
    word1 = '0;
    for (int b = 0; b < NBE; b++) begin
      if (mask_q[b]) begin
        word1[b*8 +: 8] = byp_q[b] ? wdata_q[b*8 +: 8] : ram_word[b*8 +: 8];
      end
    end
  end

  if (LAT == 2) begin : g_lat2
    logic [WIDTH-1:0] data2_q, data2_d;
    logic             valid2_q;

    // Second stage only loads on a returning read so the output holds between reads.
    always_comb data2_d = valid1_q ? word1 : data2_q;

    // Output register stage.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        data2_q  <= '0;
        valid2_q <= 1'b0;
      end else begin
        data2_q  <= data2_d;
        valid2_q <= valid1_q;
      end
    end

    assign rd_data  = data2_q;
    assign rd_valid = valid2_q;
  end else begin : g_lat1
    assign rd_data  = word1;
    assign rd_valid = valid1_q;
  end

endmodule

// File: rtl/mem_nr1w.sv
// Byte-writable memory with one write port and NRD independent pipelined read ports.
// Per-byte written flags are reset; the data array is not, the flags mask it instead.
module mem_nr1w
  import mem_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 256,
  parameter  int NRD      = 2,
  parameter  int LAT      = 1,
  parameter  bit WR_FIRST = 1'b1,
  localparam int AW       = $clog2(DEPTH),
  localparam int NBE      = WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [AW-1:0]             write_addr,
  input  logic [WIDTH-1:0]          write_data,
  input  logic [NBE-1:0]            write_be,
  input  logic [NRD-1:0]            re,
  input  logic [NRD-1:0][AW-1:0]    read_addr,
  output logic [NRD-1:0][WIDTH-1:0] read_data,
  output logic [NRD-1:0]            read_valid
);

  if (!params_ok(WIDTH, LAT, NRD)) begin : g_bad_params
    $error("mem_nr1w: illegal parameters WIDTH=%0d LAT=%0d NRD=%0d", WIDTH, LAT, NRD);
  end

  logic [WIDTH-1:0]          mem_array [DEPTH];
  logic [DEPTH-1:0][NBE-1:0] flag_q, flag_d;
  logic                      wr_ok;

  // Out-of-range or all-disabled writes leave every piece of state untouched.
  assign wr_ok = we && (32'(write_addr) < 32'(DEPTH)) && (write_be != '0);

  // Byte-enabled array write; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int b = 0; b < NBE; b++) begin
        if (write_be[b]) mem_array[write_addr][b*8 +: 8] <= write_data[b*8 +: 8];
      end
    end
  end

  // Mark written bytes at the write address.
  always_comb begin
    flag_d = flag_q;
    if (wr_ok) flag_d[write_addr] = flag_q[write_addr] | write_be;
  end

  // Written flags clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag_q <= '0;
    else      flag_q <= flag_d;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_port
    logic             in_range;
    logic [AW-1:0]    ix;
    logic [NBE-1:0]   flags_sel;
    logic [WIDTH-1:0] ram_q;

    assign in_range  = 32'(read_addr[gi]) < 32'(DEPTH);
    assign ix        = in_range ? read_addr[gi] : '0;
    assign flags_sel = flag_q[ix];

    // Registered array read, enabled by the port's request (maps onto a RAM read port).
    always_ff @(posedge clk) begin
      if (re[gi]) ram_q <= mem_array[ix];
    end

    mem_rd_port #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .LAT     (LAT),
      .WR_FIRST(WR_FIRST)
    ) u_rd_port (
      .clk       (clk),
      .rst       (rst),
      .re        (re[gi]),
      .addr      (read_addr[gi]),
      .wr_ok     (wr_ok),
      .write_addr(write_addr),
      .write_data(write_data),
      .write_be  (write_be),
      .flags     (flags_sel),
      .ram_word  (ram_q),
      .rd_data   (read_data[gi]),
      .rd_valid  (read_valid[gi])
    );
  end

endmodule

// File: tb/tb_mem_nr1w.sv
// Bench for mem_nr1w: two instances (defaults; and DEPTH=200/LAT=2/read-old) driven with
// the same stimulus, each compared every cycle against a word/byte-level reference model.
module tb_mem_nr1w;
  import mem_pkg::*;

  localparam int NRD = 2;
  localparam int AW  = 8;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   we = 1'b0;
  logic [AW-1:0]          write_addr = '0;
  word_t                  write_data = '0;
  be_t                    write_be = '0;
  logic [NRD-1:0]         re = '0;
  logic [NRD-1:0][AW-1:0] read_addr = '0;
  logic [NRD-1:0][31:0]   rd0, rd1;
  logic [NRD-1:0]         rv0, rv1;

  always #5 clk = ~clk;

  mem_nr1w #(.WIDTH(32), .DEPTH(256), .NRD(NRD), .LAT(1), .WR_FIRST(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .write_be(write_be), .re(re), .read_addr(read_addr), .read_data(rd0), .read_valid(rv0));

  mem_nr1w #(.WIDTH(32), .DEPTH(200), .NRD(NRD), .LAT(2), .WR_FIRST(1'b0)) u_dut1 (
    .clk(clk), .rst(rst), .we(we), .write_addr(write_addr), .write_data(write_data),
    .write_be(write_be), .re(re), .read_addr(read_addr), .read_data(rd1), .read_valid(rv1));

  // ---------------- reference model ----------------
  typedef struct packed { logic [31:0] due; logic [31:0] data; } ev_t;

  logic [7:0]  m_mem  [2][256][4];
  bit          m_flag [2][256][4];
  ev_t         evq    [2][NRD][$];
  logic [31:0] last   [2][NRD];
  int          pulses [2][NRD];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic int dep(input int i); return (i == 0) ? 256 : 200; endfunction
  function automatic int lat(input int i); return (i == 0) ? 1 : 2;     endfunction
  function automatic bit wrf(input int i); return (i == 0);             endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Value a read of address a returns, given the write presented on the same edge.
  function automatic logic [31:0] expect_word(input int i, input int a);
    logic [31:0] w;
    w = '0;
    if (a >= dep(i)) return w;
    for (int b = 0; b < 4; b++) begin
      if (wrf(i) && we && write_be[b] && int'(write_addr) == a) w[b*8 +: 8] = write_data[b*8 +: 8];
      else if (m_flag[i][a][b])                                 w[b*8 +: 8] = m_mem[i][a][b];
    end
    return w;
  endfunction

  task automatic model_edge();
    ev_t ev;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NRD; p++)
        if (re[p]) begin
          ev.due  = 32'(cyc + lat(i) - 1);
          ev.data = expect_word(i, int'(read_addr[p]));
          evq[i][p].push_back(ev);
        end
    for (int i = 0; i < 2; i++)
      if (we && int'(write_addr) < dep(i))
        for (int b = 0; b < 4; b++)
          if (write_be[b]) begin
            m_mem[i][write_addr][b]  = write_data[b*8 +: 8];
            m_flag[i][write_addr][b] = 1'b1;
          end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int a = 0; a < 256; a++)
        for (int b = 0; b < 4; b++) m_flag[i][a][b] = 1'b0;
      for (int p = 0; p < NRD; p++) begin
        evq[i][p].delete();
        last[i][p] = '0;
      end
    end
  endtask

  task automatic check_outputs();
    logic        exp_v, got_v;
    logic [31:0] exp_d, got_d;
    ev_t         ev;
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NRD; p++) begin
        exp_v = 1'b0;
        exp_d = last[i][p];
        if (evq[i][p].size() > 0 && evq[i][p][0].due == 32'(cyc)) begin
          ev = evq[i][p].pop_front();
          exp_v = 1'b1;
          exp_d = ev.data;
          last[i][p] = ev.data;
        end
        got_v = (i == 0) ? rv0[p] : rv1[p];
        got_d = (i == 0) ? rd0[p] : rd1[p];
        if (got_v) pulses[i][p]++;
        check($sformatf("dut%0d.valid%0d", i, p), 32'(got_v), 32'(exp_v));
        check($sformatf("dut%0d.data%0d", i, p), got_d, exp_d);
      end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    we = 1'b0; write_be = '0; re = '0;
  endtask

  task automatic set_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    we = 1'b1; write_addr = AW'(a); write_data = d; write_be = be;
  endtask

  task automatic set_rd(input int p, input int a);
    re[p] = 1'b1; read_addr[p] = AW'(a);
  endtask

  // One clock: model sees the inputs the DUT sampled, outputs are checked 1ns later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_edge();
    #1;
    if (we || re != '0)
      $display("cyc=%0d rst=%0b we=%0b wa=%0d wd=%h be=%b re=%b ra=%0d/%0d d0=%h/%h d1=%h/%h",
               cyc, rst, we, write_addr, write_data, write_be, re, read_addr[0], read_addr[1],
               rd0[0], rd0[1], rd1[0], rd1[1]);
    check_outputs();
  endtask

  task automatic apply_reset(input int n);
    idle();
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (n) step();
    rst = 1'b1;
  endtask

  int a_sel;

  initial begin
    for (int i = 0; i < 2; i++)
      for (int a = 0; a < 256; a++)
        for (int b = 0; b < 4; b++) m_mem[i][a][b] = 8'h00;
    model_reset();
    idle();
    repeat (2) step();
    rst = 1'b1;

    // Write then read back a full word.
    set_wr(4, 32'd42, 4'hF); step(); idle();
    set_rd(0, 4); step(); idle();
    check("req033_lat1", rd0[0], 32'd42);
    step();
    check("req033_lat2", rd1[0], 32'd42);
    step();

    // Same-cycle partial write and read of the same address.
    set_wr(4, 32'h11223344, 4'hF); step(); idle();
    set_wr(4, 32'hAABBCCDD, 4'b0011); set_rd(0, 4); step(); idle();
    check("req034_new", rd0[0], 32'h1122CCDD);
    set_rd(0, 4); step(); idle();
    check("req034_old", rd1[0], 32'h11223344);
    step();
    check("req034_after", rd1[0], 32'h1122CCDD);
    step();

    // Back-to-back reads on both ports.
    set_wr(5, 32'h5A5AC3C3, 4'hF); step(); idle();
    for (int i = 0; i < 2; i++) for (int p = 0; p < NRD; p++) pulses[i][p] = 0;
    for (int k = 0; k < 8; k++) begin set_rd(0, 4); set_rd(1, 5); step(); end
    idle(); step(); step();
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < NRD; p++) check($sformatf("req036_pulses%0d_%0d", i, p), 32'(pulses[i][p]), 32'd8);

    // Out-of-range write on the DEPTH=200 instance must not alias onto address 50.
    set_wr(50, 32'h0A0B0C0D, 4'hF); step();
    set_wr(250, 32'd9, 4'hF); step(); idle();
    set_rd(0, 250); set_rd(1, 50); step(); idle();
    check("req037_d256_250", rd0[0], 32'd9);
    check("req037_d256_50", rd0[1], 32'h0A0B0C0D);
    step();
    check("req037_d200_250", rd1[0], 32'd0);
    check("req037_d200_valid", 32'(rv1[0]), 32'd1);
    check("req037_d200_50", rd1[1], 32'h0A0B0C0D);
    step();

    // Reset masks previously written data; a single-byte write shows only that byte.
    apply_reset(2);
    set_wr(7, 32'hFFFFFFFF, 4'b0001); step(); idle();
    set_rd(0, 7); step(); idle();
    check("req035_lat1", rd0[0], 32'h000000FF);
    step();
    check("req035_lat2", rd1[0], 32'h000000FF);
    step();

    // Reset while a LAT=2 read is in flight.
    set_wr(4, 32'hDEADBEEF, 4'hF); step(); idle();
    set_rd(0, 4); step(); idle();
    apply_reset(1);
    repeat (3) step();
    set_rd(0, 4); step(); idle();
    step();
    check("req038_data", rd1[0], 32'd0);
    check("req038_valid", 32'(rv1[0]), 32'd1);
    step();

    // Randomized traffic, addresses clustered to force collisions and range edges.
    for (int k = 0; k < 400; k++) begin
      idle();
      a_sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(190, 255)) : int'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) set_wr(a_sel, $urandom, 4'($urandom_range(0, 15)));
      for (int p = 0; p < NRD; p++)
        if ($urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 2) == 0) set_rd(p, a_sel);
          else if ($urandom_range(0, 3) == 0) set_rd(p, int'($urandom_range(190, 255)));
          else set_rd(p, int'($urandom_range(0, 15)));
        end
      if ($urandom_range(0, 149) == 0) apply_reset(1);
      else step();
    end
    idle();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
